// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - ESM config bus types, frame magic, module ids and control message types
package esm_pkg;

   typedef struct packed {
      logic        valid;
      logic        first;
      logic        last;
      logic [7:0]  module_id;
      logic [7:0]  message_type;
      logic [31:0] data;
   } esm_config_data_t;

   localparam logic [31:0] esm_control_magic_num = 32'hE5C0_4D5A;

   localparam logic [7:0] esm_module_id_control          = 8'd0;
   localparam logic [7:0] esm_module_id_dwell_controller = 8'd1;
   localparam logic [7:0] esm_module_id_status_reporter  = 8'd2;

   localparam logic [7:0] esm_control_message_type_enable        = 8'd0;
   localparam logic [7:0] esm_control_message_type_dwell_entry   = 8'd1;
   localparam logic [7:0] esm_control_message_type_dwell_program = 8'd2;

   function automatic logic is_enable_msg(input logic [7:0] module_id, input logic [7:0] message_type);
      return (module_id == esm_module_id_control) && (message_type == esm_control_message_type_enable);
   endfunction

endpackage

// File: rtl/esm_config_ctrl_decode.sv
// rtl/esm_config_ctrl_decode.sv - registers the enable-message word into reset/enable levels
module esm_config_ctrl_decode (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Load,
   input  logic [31:0] Data,
   output logic        Rst_out,
   output logic        Enable_status,
   output logic [1:0]  Enable_chan,
   output logic [1:0]  Enable_pdw
);

   // Downstream blocks come out of reset held in reset with everything disabled.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Rst_out       <= 1'b1;
         Enable_status <= 1'b0;
         Enable_chan   <= 2'b00;
         Enable_pdw    <= 2'b00;
      end else if (Load) begin
         Rst_out       <= Data[24];
         Enable_status <= Data[0];
         Enable_chan   <= Data[9:8];
         Enable_pdw    <= Data[17:16];
      end
   end

endmodule

// File: rtl/esm_config_rx.sv
// rtl/esm_config_rx.sv - ESM control message receiver: frame parse, enable decode, config forwarding
// Optional sequence-number checking is enabled by defining ESM_CONFIG_SEQ_CHECK_EN.
module esm_config_rx
   import esm_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                      S_axis_clk,
   input  logic                      S_axis_resetn,
   output logic                      S_axis_ready,
   input  logic                      S_axis_valid,
   input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
   input  logic                      S_axis_last,
   output logic                      Rst_out,
   output logic                      Enable_status,
   output logic [1:0]                Enable_chan,
   output logic [1:0]                Enable_pdw,
   output logic                      Seq_error,
   output esm_config_data_t          Module_config
);

   generate
      if (AXI_DATA_WIDTH != 32) begin : g_width_check
         $error("esm_config_rx: only AXI_DATA_WIDTH=32 is supported");
      end
   endgenerate

   localparam logic [2:0] S_MAGIC   = 3'd0;
   localparam logic [2:0] S_SEQ     = 3'd1;
   localparam logic [2:0] S_TYPE    = 3'd2;
   localparam logic [2:0] S_PAD     = 3'd3;
   localparam logic [2:0] S_PAYLOAD = 3'd4;
   localparam logic [2:0] S_DROP    = 3'd5;

   logic [2:0]       state;
   logic             ready_q;
   logic             accept;
   logic             payload_first;
   logic [7:0]       mod_id_q;
   logic [7:0]       msg_type_q;
   logic             seq_ok;
   logic             ctrl_load;
   esm_config_data_t cfg_q;

   assign S_axis_ready  = ready_q;
   assign accept        = S_axis_valid & ready_q;
   assign Module_config = cfg_q;
   assign ctrl_load     = accept && (state == S_PAYLOAD) && payload_first && is_enable_msg(mod_id_q, msg_type_q);

`ifdef ESM_CONFIG_SEQ_CHECK_EN
   logic [31:0] exp_seq;
   logic        seq_err_q;

   assign seq_ok    = (S_axis_data[31:0] == exp_seq);
   assign Seq_error = seq_err_q;

   // Match or mismatch, the next expected number follows the one just received.
   always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
      if (!S_axis_resetn) begin
         exp_seq   <= 32'd0;
         seq_err_q <= 1'b0;
      end else begin
         seq_err_q <= accept && (state == S_SEQ) && !seq_ok;
         if (accept && (state == S_SEQ))
            exp_seq <= S_axis_data[31:0] + 32'd1;
      end
   end
`else
   assign seq_ok    = 1'b1;
   assign Seq_error = 1'b0;
`endif

   always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
      if (!S_axis_resetn) begin
         ready_q       <= 1'b0;
         state         <= S_MAGIC;
         payload_first <= 1'b0;
         mod_id_q      <= 8'd0;
         msg_type_q    <= 8'd0;
         cfg_q         <= '0;
      end else begin
         ready_q     <= 1'b1;
         cfg_q.valid <= 1'b0;
         if (accept) begin
            case (state)
               S_MAGIC: state <= (S_axis_data[31:0] == esm_control_magic_num) ? S_SEQ : S_DROP;
               S_SEQ:   state <= seq_ok ? S_TYPE : S_DROP;
               S_TYPE: begin
                  mod_id_q   <= S_axis_data[31:24];
                  msg_type_q <= S_axis_data[23:16];
                  state      <= S_PAD;
               end
               S_PAD: begin
                  payload_first <= 1'b1;
                  state         <= S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  payload_first <= 1'b0;
                  // Control-module payloads are consumed locally, never forwarded.
                  if (mod_id_q != esm_module_id_control) begin
                     cfg_q.valid        <= 1'b1;
                     cfg_q.first        <= payload_first;
                     cfg_q.last         <= S_axis_last;
                     cfg_q.module_id    <= mod_id_q;
                     cfg_q.message_type <= msg_type_q;
                     cfg_q.data         <= S_axis_data[31:0];
                  end
               end
               default: state <= S_DROP;
            endcase
            if (S_axis_last)
               state <= S_MAGIC;
         end
      end
   end

   esm_config_ctrl_decode u_ctrl_decode (
      .Clk           (S_axis_clk),
      .Rst_n         (S_axis_resetn),
      .Load          (ctrl_load),
      .Data          (S_axis_data[31:0]),
      .Rst_out       (Rst_out),
      .Enable_status (Enable_status),
      .Enable_chan   (Enable_chan),
      .Enable_pdw    (Enable_pdw)
   );

endmodule

// File: tb/tb_esm_config_rx.sv
// tb/tb_esm_config_rx.sv - scoreboard bench for esm_config_rx with a message-level reference model
// Model honours ESM_CONFIG_SEQ_CHECK_EN the same way the build does.
module tb_esm_config_rx;
   import esm_pkg::*;

   typedef logic [31:0] wq_t[$];

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             ready;
   logic             valid = 1'b0;
   logic [31:0]      data = 32'd0;
   logic             last = 1'b0;
   logic             rst_out, en_status, seq_error;
   logic [1:0]       en_chan, en_pdw;
   esm_config_data_t mcfg;

   always #5 clk = ~clk;

   esm_config_rx #(.AXI_DATA_WIDTH(32)) dut (
      .S_axis_clk    (clk),
      .S_axis_resetn (resetn),
      .S_axis_ready  (ready),
      .S_axis_valid  (valid),
      .S_axis_data   (data),
      .S_axis_last   (last),
      .Rst_out       (rst_out),
      .Enable_status (en_status),
      .Enable_chan   (en_chan),
      .Enable_pdw    (en_pdw),
      .Seq_error     (seq_error),
      .Module_config (mcfg)
   );

   int n_cmp = 0;
   int n_fail = 0;
   esm_config_data_t exp_q[$];
   int exp_seq_err = 0;
   int got_seq_err = 0;

   // Reference model state: decoded levels and expected sequence number.
   logic        m_rst = 1'b1;
   logic        m_stat = 1'b0;
   logic [1:0]  m_chan = 2'b00;
   logic [1:0]  m_pdw = 2'b00;
   logic [31:0] m_exp_seq = 32'd0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void model_msg(input wq_t m);
      esm_config_data_t e;
      logic [7:0] mod, typ;
      if (m.size() < 1 || m[0] != esm_control_magic_num) return;
`ifdef ESM_CONFIG_SEQ_CHECK_EN
      if (m.size() >= 2) begin
         if (m[1] != m_exp_seq) begin
            exp_seq_err++;
            m_exp_seq = m[1] + 32'd1;
            return;
         end
         m_exp_seq = m_exp_seq + 32'd1;
      end
`endif
      if (m.size() < 5) return;
      mod = m[2][31:24];
      typ = m[2][23:16];
      if (mod == 8'd0) begin
         if (typ == 8'd0) begin
            m_stat = m[4][0];
            m_chan = m[4][9:8];
            m_pdw  = m[4][17:16];
            m_rst  = m[4][24];
         end
      end else begin
         for (int i = 4; i < m.size(); i++) begin
            e.valid        = 1'b1;
            e.first        = (i == 4);
            e.last         = (i == m.size() - 1);
            e.module_id    = mod;
            e.message_type = typ;
            e.data         = m[i];
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic wq_t mk_hdr(input logic [31:0] seq, input logic [7:0] mod, input logic [7:0] typ);
      wq_t m;
      m.push_back(esm_control_magic_num);
      m.push_back(seq);
      m.push_back({mod, typ, 16'h0});
      m.push_back(32'hDEADBEEF);
      return m;
   endfunction

   task automatic send_msg(input wq_t m, input int gap_pct);
      int tries;
      model_msg(m);
      for (int i = 0; i < m.size(); i++) begin
         if ($urandom_range(99) < gap_pct) begin
            @(negedge clk);
            valid = 1'b0;
            last  = 1'b0;
         end
         @(negedge clk);
         valid = 1'b1;
         data  = m[i];
         last  = (i == m.size() - 1);
         tries = 0;
         while (!ready && tries < 20) begin
            @(negedge clk);
            tries++;
         end
         if (!ready) check("ready_timeout", {63'd0, ready}, 64'd1);
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid = 1'b0;
         last  = 1'b0;
      end
   endtask

   task automatic check_ctrl(input string tag);
      check({tag, "_rst_out"}, {63'd0, rst_out}, {63'd0, m_rst});
      check({tag, "_en_status"}, {63'd0, en_status}, {63'd0, m_stat});
      check({tag, "_en_chan"}, {62'd0, en_chan}, {62'd0, m_chan});
      check({tag, "_en_pdw"}, {62'd0, en_pdw}, {62'd0, m_pdw});
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      resetn = 1'b0;
      valid  = 1'b0;
      last   = 1'b0;
      repeat (2) @(negedge clk);
      m_rst = 1'b1; m_stat = 1'b0; m_chan = 2'b00; m_pdw = 2'b00; m_exp_seq = 32'd0;
      check({tag, "_ready_in_reset"}, {63'd0, ready}, 64'd0);
      check({tag, "_cfg_valid_in_reset"}, {63'd0, mcfg.valid}, 64'd0);
      check({tag, "_seq_err_in_reset"}, {63'd0, seq_error}, 64'd0);
      check_ctrl({tag, "_reset"});
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, "_ready_after_release"}, {63'd0, ready}, 64'd1);
   endtask

   // Scoreboard monitor, independent of stimulus.
   always @(negedge clk) begin
      if (resetn) begin
         if (seq_error) got_seq_err++;
         if (mcfg.valid) begin
            if (exp_q.size() == 0) check("cfg_unexpected_word", 64'(mcfg), 64'd0);
            else check("cfg_word", 64'(mcfg), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wq_t m;
      logic [7:0] mod;
      logic [31:0] seq;
      int kind, len;

      do_reset("por");

      m = mk_hdr(32'd0, esm_module_id_control, esm_control_message_type_enable);
      m.push_back(32'h0100_0000); m.push_back(32'hDEADBEEF);
      send_msg(m, 0);
      idle(2);
      check_ctrl("ctrl_msg0");
      m = mk_hdr(32'd1, esm_module_id_control, esm_control_message_type_enable);
      m.push_back(32'h0003_0300); m.push_back(32'hDEADBEEF);
      send_msg(m, 0);
      idle(2);
      check_ctrl("ctrl_msg1");
      check("ctrl_msg1_rst_literal", {63'd0, rst_out}, 64'd0);
      check("ctrl_msg1_chan_literal", {62'd0, en_chan}, 64'd3);

      m = mk_hdr(32'd2, esm_module_id_dwell_controller, esm_control_message_type_dwell_entry);
      for (int i = 0; i < 10; i++) m.push_back($urandom);
      send_msg(m, 30);
      idle(3);
      check("dwell_all_words_seen", exp_q.size(), 64'd0);

      m = {32'h1234_5678};
      for (int i = 0; i < 6; i++) m.push_back($urandom);
      send_msg(m, 0);
      idle(2);
      check_ctrl("bad_magic");
      m = mk_hdr(32'd3, esm_module_id_control, esm_control_message_type_enable);
      m.push_back(32'h0100_0101);
      send_msg(m, 0);
      idle(2);
      check_ctrl("after_bad_magic");

      m = mk_hdr(32'd4, esm_module_id_control, esm_control_message_type_enable);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         valid = 1'b1; data = m[i]; last = 1'b0;
         @(posedge clk);
      end
      do_reset("mid_msg");
      m = mk_hdr(32'd0, esm_module_id_control, esm_control_message_type_enable);
      m.push_back(32'h0003_0300);
      send_msg(m, 0);
      idle(2);
      check_ctrl("after_mid_reset");

      m = mk_hdr(32'd1, esm_module_id_control, esm_control_message_type_enable);
      m.push_back(32'h0002_0001);
      send_msg(m, 0);
      m = mk_hdr(32'd5, esm_module_id_dwell_controller, esm_control_message_type_dwell_program);
      m.push_back(32'hA5A5_0001); m.push_back(32'hA5A5_0002);
      send_msg(m, 0);
      m = mk_hdr(32'd6, esm_module_id_status_reporter, esm_control_message_type_dwell_entry);
      m.push_back(32'h5A5A_0003);
      send_msg(m, 0);
      idle(3);
      check("seq_directed_pulses", got_seq_err, exp_seq_err);
      check_ctrl("seq_directed");

      for (int k = 0; k < 60; k++) begin
         kind = $urandom_range(9);
`ifdef ESM_CONFIG_SEQ_CHECK_EN
         seq = ($urandom_range(4) == 0) ? m_exp_seq + $urandom_range(1, 5) : m_exp_seq;
`else
         seq = $urandom;
`endif
         case ($urandom_range(3))
            0: mod = esm_module_id_control;
            1: mod = esm_module_id_dwell_controller;
            2: mod = esm_module_id_status_reporter;
            default: mod = 8'($urandom_range(3, 255));
         endcase
         m = mk_hdr(seq, mod, 8'($urandom_range(0, 3)));
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) m.push_back($urandom);
         if (kind == 0) m[0] = m[0] ^ (32'd1 << $urandom_range(31));
         if (kind == 1) begin
            len = $urandom_range(1, 4);
            m = m[0:len-1];
         end
         send_msg(m, 20);
         if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);
      check_ctrl("random_end");
      check("cfg_queue_drained", exp_q.size(), 64'd0);
      check("seq_error_pulses", got_seq_err, exp_seq_err);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
